bpc_dbx_block_enc: RTL and testbench

- Parametrised BPC front-end stage that collects BLOCK_SIZE input words into a block.
- Computes the base word, the intra-block deltas, the delta bit-planes (DBP) and the XOR'd planes (DBX), and presents them as one registered block to the downstream sequential coder.
- Generalises the fixed-width DBP/DBX stage: DATA_W, BLOCK_SIZE and signedness are parameters.
- Adds zero-padded flush with a last-block marker, and overlaps filling of the next block with a stalled output.

---
 rtl/bpc_dbx_block_enc_if.sv | 33 +++
 rtl/bpc_dbx_block_enc.sv | 161 ++++++++++++++++
 tb/tb_bpc_dbx_block_enc.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpc_dbx_block_enc_if.sv
// Handshake and block bus between the BPC word source,
// the DBP/DBX block stage and the sequential coder.
interface bpc_dbx_block_enc_if #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8
);
    localparam int PW = DATA_W + 1;
    localparam int NB = BLOCK_SIZE - 1;

    logic [DATA_W-1:0] data_i;
    logic              vld_i;
    logic              rdy_o;
    logic              flush_i;
    logic [DATA_W-1:0] base_o;
    logic [PW*NB-1:0]  dbp_o;
    logic [PW*NB-1:0]  dbx_o;
    logic              last_o;
    logic              vld_o;
    logic              rdy_i;
    logic              idle_o;

    modport slave (
        input  data_i, vld_i, flush_i, rdy_i,
        output rdy_o, base_o, dbp_o, dbx_o,
        output last_o, vld_o, idle_o
    );

    modport master (
        output data_i, vld_i, flush_i, rdy_i,
        input  rdy_o, base_o, dbp_o, dbx_o,
        input  last_o, vld_o, idle_o
    );
endinterface

// File: rtl/bpc_dbx_block_enc.sv
// BPC block stage: gathers BLOCK_SIZE words, emits base,
// delta bit-planes and XOR'd planes as one registered block.
module bpc_dbx_block_enc #(
    parameter int DATA_W      = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int SIGNED_DATA = 0
) (
    input logic                clk_i,
    input logic                rst_i,
    bpc_dbx_block_enc_if.slave bus
);
    localparam int PW = DATA_W + 1;
    localparam int NB = BLOCK_SIZE - 1;
    localparam int CW = $clog2(BLOCK_SIZE + 1);
    localparam logic [CW-1:0] FULL = CW'(BLOCK_SIZE);

    logic [DATA_W-1:0] buf_q [BLOCK_SIZE];
    logic [DATA_W-1:0] buf_d [BLOCK_SIZE];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flushing_q, flushing_d;
    logic              lastp_q, lastp_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [PW*NB-1:0]  dbp_q, dbp_d;
    logic [PW*NB-1:0]  dbx_q, dbx_d;

    logic              full, acc, out_free;
    logic              load, blk_last;
    logic [CW-1:0]     cnt_a, wr_idx;
    logic [DATA_W-1:0] word [BLOCK_SIZE];
    logic [PW-1:0]     ext  [BLOCK_SIZE];
    logic [PW-1:0]     dlt  [NB];
    logic [PW-1:0]     dx   [NB];
    logic [PW*NB-1:0]  dbp_c, dbx_c;

    assign full     = cnt_q == FULL;
    assign out_free = !vld_q || bus.rdy_i;
    assign bus.rdy_o = !(full && !out_free) && !flushing_q;
    assign acc      = bus.vld_i && bus.rdy_o;
    assign cnt_a    = cnt_q + CW'(acc);
    assign wr_idx   = full ? '0 : cnt_q;

    // Block view: held words, bypassed incoming word, zero padding
    always_comb begin
        dbp_c = '0;
        dbx_c = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (CW'(i) < cnt_q)
                word[i] = buf_q[i];
            else if (acc && CW'(i) == cnt_q)
                word[i] = bus.data_i;
            else
                word[i] = '0;
            if (SIGNED_DATA != 0)
                ext[i] = {word[i][DATA_W-1], word[i]};
            else
                ext[i] = {1'b0, word[i]};
        end
        for (int j = 0; j < NB; j++) begin
            dlt[j] = ext[j+1] - ext[j];
            dx[j]  = dlt[j] ^ (dlt[j] >> 1);
            for (int b = 0; b < PW; b++) begin
                dbp_c[b*NB+j] = dlt[j][b];
                dbx_c[b*NB+j] = dx[j][b];
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        flushing_d = flushing_q;
        lastp_d    = lastp_q;
        buf_d      = buf_q;
        load       = 1'b0;
        blk_last   = 1'b0;
        if (flushing_q) begin
            if (out_free) begin
                load       = 1'b1;
                blk_last   = 1'b1;
                cnt_d      = '0;
                flushing_d = 1'b0;
            end
        end else if (full) begin
            if (out_free) begin
                load       = 1'b1;
                blk_last   = lastp_q | (bus.flush_i & !acc);
                cnt_d      = CW'(acc);
                flushing_d = acc & bus.flush_i;
                lastp_d    = 1'b0;
            end else begin
                lastp_d = lastp_q | bus.flush_i;
            end
        end else begin
            cnt_d = cnt_a;
            if (cnt_a == FULL) begin
                if (out_free) begin
                    load     = 1'b1;
                    blk_last = bus.flush_i;
                    cnt_d    = '0;
                end else begin
                    lastp_d = bus.flush_i;
                end
            end else if (bus.flush_i && cnt_a != '0) begin
                flushing_d = 1'b1;
            end
        end
        for (int i = 0; i < BLOCK_SIZE; i++)
            if (acc && CW'(i) == wr_idx)
                buf_d[i] = bus.data_i;
    end

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        base_d = base_q;
        dbp_d  = dbp_q;
        dbx_d  = dbx_q;
        if (load) begin
            vld_d  = 1'b1;
            last_d = blk_last;
            base_d = word[0];
            dbp_d  = dbp_c;
            dbx_d  = dbx_c;
        end else if (bus.rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
                buf_q[i] <= '0;
            cnt_q      <= '0;
            flushing_q <= 1'b0;
            lastp_q    <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            base_q     <= '0;
            dbp_q      <= '0;
            dbx_q      <= '0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            flushing_q <= flushing_d;
            lastp_q    <= lastp_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            base_q     <= base_d;
            dbp_q      <= dbp_d;
            dbx_q      <= dbx_d;
        end
    end

    assign bus.vld_o  = vld_q;
    assign bus.last_o = last_q;
    assign bus.base_o = base_q;
    assign bus.dbp_o  = dbp_q;
    assign bus.dbx_o  = dbx_q;
    assign bus.idle_o = cnt_q == '0 && !vld_q && !flushing_q;
endmodule

// File: tb/tb_bpc_dbx_block_enc.sv
// Bench for bpc_dbx_block_enc: unsigned and signed instances
// share stimulus; a word-level scoreboard checks every block.
module tb_bpc_dbx_block_enc;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       vld, flush, rdy_in;

    int checks = 0;
    int errs   = 0;
    int pops   = 0;
    int waits  = 0;

    typedef struct {
        logic [7:0] w [4];
        bit         last;
    } blk_t;

    blk_t       q [$];
    logic [7:0] cur [$];

    bpc_dbx_block_enc_if #(.DATA_W(8), .BLOCK_SIZE(4)) bu ();
    bpc_dbx_block_enc_if #(.DATA_W(8), .BLOCK_SIZE(4)) bs ();

    assign bu.data_i  = data;
    assign bu.vld_i   = vld;
    assign bu.flush_i = flush;
    assign bu.rdy_i   = rdy_in;
    assign bs.data_i  = data;
    assign bs.vld_i   = vld;
    assign bs.flush_i = flush;
    assign bs.rdy_i   = rdy_in;

    bpc_dbx_block_enc #(
        .DATA_W(8), .BLOCK_SIZE(4), .SIGNED_DATA(0)
    ) u_dut (.clk_i(clk), .rst_i(rst), .bus(bu.slave));

    bpc_dbx_block_enc #(
        .DATA_W(8), .BLOCK_SIZE(4), .SIGNED_DATA(1)
    ) s_dut (.clk_i(clk), .rst_i(rst), .bus(bs.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on integer word values
    function automatic void mk(input blk_t e, input bit sg,
                               output logic [7:0] base,
                               output logic [26:0] p,
                               output logic [26:0] x);
        int v [4];
        int d, dx;
        for (int i = 0; i < 4; i++)
            v[i] = (sg && e.w[i] >= 128) ?
                   int'(e.w[i]) - 256 : int'(e.w[i]);
        base = e.w[0];
        p = '0;
        x = '0;
        for (int j = 0; j < 3; j++) begin
            d  = (v[j+1] - v[j]) & 'h1FF;
            dx = d ^ (d >> 1);
            for (int b = 0; b < 9; b++) begin
                p[b*3+j] = d[b];
                x[b*3+j] = dx[b];
            end
        end
    endfunction

    task automatic emit(input bit last);
        blk_t e;
        for (int i = 0; i < 4; i++)
            e.w[i] = (i < cur.size()) ? cur[i] : 8'h00;
        e.last = last;
        q.push_back(e);
        cur.delete();
    endtask

    always @(negedge clk) begin
        blk_t e;
        logic [7:0]  b;
        logic [26:0] p, x;
        if (rst) begin
            q.delete();
            cur.delete();
        end else begin
            if (rdy_in && bu.vld_o) begin
                if (q.size() == 0) begin
                    chk("sb_spurious", bu.base_o, 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    pops++;
                    mk(e, 1'b0, b, p, x);
                    chk("u_base", bu.base_o, b);
                    chk("u_dbp", bu.dbp_o, p);
                    chk("u_dbx", bu.dbx_o, x);
                    chk("u_last", bu.last_o, e.last);
                    mk(e, 1'b1, b, p, x);
                    chk("s_vld", bs.vld_o, 1'b1);
                    chk("s_dbp", bs.dbp_o, p);
                    chk("s_dbx", bs.dbx_o, x);
                    chk("s_last", bs.last_o, e.last);
                end
            end
            if (vld && bu.rdy_o) begin
                cur.push_back(data);
                if (cur.size() == 4) emit(flush);
                else if (flush) emit(1'b1);
            end else if (flush && cur.size() > 0) begin
                emit(1'b1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] w, input bit f);
        int n = 0;
        data = w;
        vld  = 1'b1;
        flush = 1'b0;
        forever begin
            @(negedge clk);
            if (bu.rdy_o) begin
                flush = f;
                break;
            end
            waits++;
            n++;
            if (n >= 3) rdy_in = 1'b1;
            if (n > 60) begin
                checks++;
                errs++;
                $error("FAIL put_timeout: observed=%0d expected=0",
                       n);
                break;
            end
        end
        cyc();
        vld = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        blk_t e;
        logic [7:0]  b;
        logic [26:0] p, x;
        int p0, w0;
        logic [7:0] a0;

        rst = 1'b1; vld = 1'b0; flush = 1'b0;
        rdy_in = 1'b1; data = '0;
        repeat (3) cyc();
        chk("rst_vld", bu.vld_o, 1'b0);
        chk("rst_rdy", bu.rdy_o, 1'b1);
        chk("rst_idle", bu.idle_o, 1'b1);
        chk("rst_base", bu.base_o, 8'h00);
        chk("rst_dbp", bu.dbp_o, 27'h0);
        chk("rst_dbx", bu.dbx_o, 27'h0);
        chk("rst_last", bu.last_o, 1'b0);
        rst = 1'b0;
        cyc();

        put(8'd10, 0); put(8'd12, 0); put(8'd12, 0);
        chk("t1_early_vld", bu.vld_o, 1'b0);
        put(8'd11, 0);
        chk("t1_vld", bu.vld_o, 1'b1);
        chk("t1_base", bu.base_o, 8'd10);
        chk("t1_dbp", bu.dbp_o,
            {{7{3'b100}}, 3'b101, 3'b100});
        chk("t1_dbx", bu.dbx_o,
            {3'b100, {6{3'b000}}, 3'b001, 3'b001});
        chk("t1_last", bu.last_o, 1'b0);
        cyc();

        p0 = pops; w0 = waits;
        for (int i = 0; i < 12; i++)
            put(8'($urandom), 0);
        cyc();
        chk("stream_blocks", pops - p0, 3);
        chk("stream_stall", waits - w0, 0);

        rdy_in = 1'b0;
        a0 = 8'($urandom);
        put(a0, 0);
        for (int i = 0; i < 3; i++) put(8'($urandom), 0);
        for (int i = 0; i < 4; i++) put(8'($urandom), 0);
        data = 8'h5A;
        vld  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_rdy", bu.rdy_o, 1'b0);
            chk("stall_base", bu.base_o, a0);
            chk("stall_vld", bu.vld_o, 1'b1);
        end
        cyc();
        p0 = pops;
        rdy_in = 1'b1;
        put(8'h5A, 0);
        for (int i = 0; i < 3; i++) put(8'($urandom), 0);
        repeat (3) cyc();
        chk("stall_drain", pops - p0, 3);

        put(8'd5, 0); put(8'd7, 0);
        flush = 1'b1;
        cyc();
        chk("fl_rdy_low", bu.rdy_o, 1'b0);
        chk("fl_vld_early", bu.vld_o, 1'b0);
        cyc();
        flush = 1'b0;
        e.w = '{8'd5, 8'd7, 8'd0, 8'd0};
        e.last = 1'b1;
        mk(e, 1'b0, b, p, x);
        chk("fl_rdy_back", bu.rdy_o, 1'b1);
        chk("fl_vld", bu.vld_o, 1'b1);
        chk("fl_base", bu.base_o, 8'd5);
        chk("fl_dbp", bu.dbp_o, p);
        chk("fl_last", bu.last_o, 1'b1);
        cyc();
        chk("fl_idle", bu.idle_o, 1'b1);

        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("efl_vld", bu.vld_o, 1'b0);
            chk("efl_idle", bu.idle_o, 1'b1);
        end
        flush = 1'b0;

        put(8'h7F, 0); put(8'h80, 0);
        put(8'h80, 0); put(8'h80, 0);
        chk("sg_bit8", bs.dbp_o[24], 1'b1);
        chk("sg_bit0", bs.dbp_o[0], 1'b1);
        chk("us_bit8", bu.dbp_o[24], 1'b0);
        cyc();

        put(8'd1, 0); put(8'd2, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mr_idle", bu.idle_o, 1'b1);
        chk("mr_vld", bu.vld_o, 1'b0);
        p0 = pops;
        for (int i = 0; i < 4; i++) put(8'($urandom), 0);
        cyc();
        chk("mr_block", pops - p0, 1);

        for (int i = 0; i < 60; i++) begin
            rdy_in = ($urandom_range(3) != 0);
            put(8'($urandom), ($urandom_range(5) == 0));
        end
        rdy_in = 1'b1;
        repeat (3) cyc();
        flush = 1'b1;
        repeat (2) cyc();
        flush = 1'b0;
        repeat (6) cyc();
        chk("end_queue", q.size(), 0);
        chk("end_idle", bu.idle_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
